// File: rtl/pio_out_pkg.sv
// Shared constants for the pulse-capable output PIO: register map, STATUS bit
// positions and the one-shot timer state encoding.
package pio_out_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd6;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_DONE    = 1;
  localparam int STATUS_OVERRUN = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/pio_pulse_timer.sv
// One-shot inversion timer: holds the active mask for exactly i_len clocks,
// then raises a sticky done flag; a start while busy only flags overrun.
//
// state     | meaning
// ST_IDLE   | no pulse running, active mask is zero
// ST_ACTIVE | mask applied, counter counting down to 1
module pio_pulse_timer
  import pio_out_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int PULSE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [WIDTH-1:0]       i_mask,
  input  logic [PULSE_CNT_W-1:0] i_len,
  input  logic                   i_clear,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_overrun,
  output logic [WIDTH-1:0]       o_active_mask
);

  pulse_state_e           r_state, w_state_nxt;
  logic [PULSE_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]       r_mask, w_mask_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_overrun, w_overrun_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mask    <= w_mask_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Flag sets are applied after the clear so a coincident set wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mask_nxt    = r_mask;
    w_done_nxt    = i_clear ? 1'b0 : r_done;
    w_overrun_nxt = i_clear ? 1'b0 : r_overrun;
    case (r_state)
      ST_IDLE: begin
        if (i_start && (i_len != '0) && (i_mask != '0)) begin
          w_mask_nxt  = i_mask;
          w_cnt_nxt   = i_len;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (i_start) w_overrun_nxt = 1'b1;
        if (r_cnt == PULSE_CNT_W'(1)) begin
          w_mask_nxt  = '0;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - PULSE_CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy        = (r_state == ST_ACTIVE);
  assign o_done        = r_done;
  assign o_overrun     = r_overrun;
  assign o_active_mask = r_mask;

endmodule

// File: rtl/nios_system_pio_out_pulse.sv
// Avalon-MM output PIO with set/clear and a hardware one-shot inversion pulse.
// Define PIO_OUT_PULSE_IRQ_EN to add the IRQ_MASK register and the done IRQ.
module nios_system_pio_out_pulse
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               PULSE_CNT_W = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic                   w_wr;
  logic                   w_start;
  logic                   w_clear;
  logic [WIDTH-1:0]       r_data;
  logic [PULSE_CNT_W-1:0] r_pulse_len;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_overrun;
  logic [WIDTH-1:0]       w_active_mask;
  logic [31:0]            w_rd;
  logic                   w_unused_wd;

  assign w_wr    = chipselect & ~write_n;
  assign w_start = w_wr && (address == ADDR_PULSE);
  assign w_clear = w_wr && (address == ADDR_STATUS);
  // Upper writedata bits beyond WIDTH/PULSE_CNT_W are architecturally ignored.
  assign w_unused_wd = &writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= RESET_VALUE;
      r_pulse_len <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:      r_data      <= writedata[WIDTH-1:0];
        ADDR_OUTSET:    r_data      <= r_data | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR:  r_data      <= r_data & ~writedata[WIDTH-1:0];
        ADDR_PULSE_LEN: r_pulse_len <= writedata[PULSE_CNT_W-1:0];
        default: ;
      endcase
    end
  end

  pio_pulse_timer #(
    .WIDTH       (WIDTH),
    .PULSE_CNT_W (PULSE_CNT_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (reset_n),
    .i_start       (w_start),
    .i_mask        (writedata[WIDTH-1:0]),
    .i_len         (r_pulse_len),
    .i_clear       (w_clear),
    .o_busy        (w_busy),
    .o_done        (w_done),
    .o_overrun     (w_overrun),
    .o_active_mask (w_active_mask)
  );

`ifdef PIO_OUT_PULSE_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               r_irq_en <= 1'b0;
    else if (w_wr && address == ADDR_IRQ_MASK)  r_irq_en <= writedata[0];
  end

  assign irq = w_done & r_irq_en;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:      w_rd[WIDTH-1:0] = r_data;
      ADDR_STATUS: begin
        w_rd[STATUS_BUSY]    = w_busy;
        w_rd[STATUS_DONE]    = w_done;
        w_rd[STATUS_OVERRUN] = w_overrun;
      end
      ADDR_PULSE_LEN: w_rd[PULSE_CNT_W-1:0] = r_pulse_len;
      ADDR_PULSE:     w_rd[WIDTH-1:0] = w_active_mask;
`ifdef PIO_OUT_PULSE_IRQ_EN
      ADDR_IRQ_MASK:  w_rd[0] = r_irq_en;
`endif
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_rd;
  end

  assign out_port = r_data ^ w_active_mask;

endmodule

// File: tb/tb_nios_system_pio_out_pulse.sv
// Directed self-checking bench for nios_system_pio_out_pulse (WIDTH=10,
// RESET_VALUE=10'h155); IRQ expectations follow PIO_OUT_PULSE_IRQ_EN.
module tb_nios_system_pio_out_pulse;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [9:0]  out_port;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rv;
  logic        irq_exp;

  always #5 clk = ~clk;

  nios_system_pio_out_pulse #(
    .WIDTH       (10),
    .PULSE_CNT_W (16),
    .RESET_VALUE (10'h155)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge
  // that applied the write.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
`ifdef PIO_OUT_PULSE_IRQ_EN
    irq_exp = 1'b1;
`else
    irq_exp = 1'b0;
`endif
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_port", 32'(out_port), 32'h155);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    step(1);
    rd(3'd1, rv); chk("rst_status", rv, 32'h0);

    // Direct write, set and clear
    wr(3'd0, 32'h0F0);
    wr(3'd4, 32'h003);
    wr(3'd5, 32'h010);
    chk("setclr_out_port", 32'(out_port), 32'h0E3);
    rd(3'd0, rv); chk("rd_data", rv, 32'h0E3);
    rd(3'd4, rv); chk("rd_outset_zero", rv, 32'h0);
    rd(3'd7, rv); chk("rd_reserved_zero", rv, 32'h0);

    // Five-cycle pulse
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h5);
    wr(3'd3, 32'h201);
    address = 3'd1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pulse_out_%0d", i), 32'(out_port), 32'h201);
      if (i > 0) chk($sformatf("pulse_busy_%0d", i), readdata, 32'h1);
      step(1);
    end
    chk("pulse_end_out", 32'(out_port), 32'h0);
    chk("pulse_last_busy", readdata, 32'h1);
    step(1);
    chk("pulse_done_status", readdata, 32'h2);

    // Overrun plus data update during a pulse
    wr(3'd3, 32'h201);
    wr(3'd3, 32'h3FF);
    chk("ovr_out_kept", 32'(out_port), 32'h201);
    wr(3'd4, 32'h004);
    chk("ovr_outset_live", 32'(out_port), 32'h205);
    step(2);
    chk("ovr_out_late", 32'(out_port), 32'h205);
    step(1);
    chk("ovr_out_end", 32'(out_port), 32'h004);
    rd(3'd1, rv); chk("ovr_status", rv, 32'h6);
    wr(3'd1, 32'h0);
    rd(3'd1, rv); chk("status_cleared", rv, 32'h0);
    wr(3'd0, 32'h0);

    // Ignored starts: zero length, zero mask
    wr(3'd2, 32'h0);
    wr(3'd3, 32'h3FF);
    chk("len0_out", 32'(out_port), 32'h0);
    rd(3'd1, rv); chk("len0_status", rv, 32'h0);
    wr(3'd2, 32'h2);
    wr(3'd3, 32'h0);
    rd(3'd1, rv); chk("mask0_status", rv, 32'h0);
    wr(3'd2, 32'h0001FFFF);
    rd(3'd2, rv); chk("len_max", rv, 32'h0000FFFF);

    // IRQ and clear-on-completion collision
    wr(3'd6, 32'h1);
    rd(3'd6, rv); chk("irq_mask_rd", rv, 32'(irq_exp));
    wr(3'd2, 32'h3);
    wr(3'd3, 32'h1);
    step(2);
    chk("irq_before_done", 32'(irq), 32'h0);
    wr(3'd1, 32'h0);
    chk("irq_on_done", 32'(irq), 32'(irq_exp));
    rd(3'd1, rv); chk("done_survives_clear", rv, 32'h2);
    wr(3'd1, 32'h0);
    chk("irq_after_clear", 32'(irq), 32'h0);

    // Reset mid-pulse
    wr(3'd2, 32'd100);
    wr(3'd3, 32'h080);
    rd(3'd3, rv); chk("active_mask_rd", rv, 32'h080);
    step(38);
    chk("long_pulse_out", 32'(out_port), 32'h080);
    reset_n = 1'b0;
    #1;
    chk("midrst_out", 32'(out_port), 32'h155);
    step(2);
    reset_n = 1'b1;
    step(1);
    rd(3'd1, rv); chk("midrst_status", rv, 32'h0);
    chk("midrst_out_after", 32'(out_port), 32'h155);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
